// File: rtl/oam_dma_ctrl.sv
// OAM sprite DMA controller and CPU/DMA bus multiplexer.
// A CPU store to the DMA register halts the CPU. After a settle delay the
// block takes the memory bus and copies 256 bytes from page {page,00..FF}
// to the OAM data register. It then releases the bus and the CPU.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          HALT_SETTLE   = 6,
  parameter int          READ_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_write_en,
  output logic        mem_read_en,
  input  logic [7:0]  mem_data_in,
  output logic        cpu_halt,
  output logic        dma_busy,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RD,
    WAIT,
    WR,
    DONE
  } state_t;

  // Terminal counts for the settle delay and for the read-data wait.
  localparam logic [7:0] SETTLE_LAST = 8'(HALT_SETTLE - 1);
  localparam logic [7:0] WAIT_LAST   = 8'(READ_LATENCY - 1);

  state_t      state;
  logic [7:0]  page;
  logic [7:0]  index;
  logic [7:0]  cnt;
  logic [7:0]  data;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic        dma_re;

  // The bus follows the CPU unless the DMA owns it. CPU strobes are dropped while the DMA is busy.
  assign mem_addr     = dma_busy ? dma_addr : cpu_addr;
  assign mem_data_out = dma_busy ? data     : cpu_data_out;
  assign mem_write_en = dma_busy ? dma_we   : cpu_write_en;
  assign mem_read_en  = dma_busy ? dma_re   : cpu_read_en;

  // Transfer sequencer. All bus-side DMA signals are registered on the entry edge of each state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      page     <= 8'h00;
      index    <= 8'h00;
      cnt      <= 8'h00;
      data     <= 8'h00;
      dma_addr <= 16'h0000;
      dma_we   <= 1'b0;
      dma_re   <= 1'b0;
      cpu_halt <= 1'b0;
      dma_busy <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dma_done <= 1'b0;
          // The triggering store still reaches the bus, because the mux is in pass-through.
          if (cpu_write_en && (cpu_addr == DMA_REG_ADDR)) begin
            page     <= cpu_data_out;
            index    <= 8'h00;
            cnt      <= 8'h00;
            cpu_halt <= 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          // Let the CPU finish its in-flight access before the bus is taken.
          if (cnt == SETTLE_LAST) begin
            dma_busy <= 1'b1;
            dma_addr <= {page, index};
            dma_re   <= 1'b1;
            state    <= RD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RD: begin
          dma_re <= 1'b0;
          cnt    <= 8'h00;
          state  <= WAIT;
        end
        WAIT: begin
          // Read data becomes valid READ_LATENCY cycles after the read pulse.
          if (cnt == WAIT_LAST) begin
            data     <= mem_data_in;
            dma_addr <= OAM_DATA_ADDR;
            dma_we   <= 1'b1;
            state    <= WR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WR: begin
          dma_we <= 1'b0;
          // Stop after byte FF. The page never increments.
          if (index == 8'hFF) begin
            dma_done <= 1'b1;
            state    <= DONE;
          end else begin
            index    <= index + 8'd1;
            dma_addr <= {page, index + 8'd1};
            dma_re   <= 1'b1;
            state    <= RD;
          end
        end
        DONE: begin
          dma_done <= 1'b0;
          dma_busy <= 1'b0;
          cpu_halt <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized scoreboard bench for oam_dma_ctrl.
// Two instances run side by side, one with read latency 2 and one with read latency 3.
// Each instance has its own latency-accurate memory model.
// Expected reads and OAM writes are queued when a DMA is triggered.
// A negedge monitor pops and checks them, and also checks pass-through, halt/busy windows and done timing.
module tb_oam_dma_ctrl;

  localparam int HS = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data_out = 8'h00;
  logic        cpu_write_en = 1'b0;
  logic        cpu_read_en = 1'b0;

  logic [15:0] mem_addr     [2];
  logic [7:0]  mem_data_out [2];
  logic        mem_write_en [2];
  logic        mem_read_en  [2];
  logic [7:0]  mem_data_in  [2];
  logic        cpu_halt     [2];
  logic        dma_busy     [2];
  logic        dma_done     [2];

  logic [7:0]  ram [65536];
  logic [15:0] rq [2][$];
  logic [7:0]  wq [2][$];

  int cyc = 0;
  int trig_cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int halt_cnt [2];
  int busy_cnt [2];
  bit post_done [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = gi + 2;
    logic [15:0] pa [8];
    logic        pv [8];
    logic [7:0]  junk;

    oam_dma_ctrl #(.READ_LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
      .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en),
      .mem_addr(mem_addr[gi]), .mem_data_out(mem_data_out[gi]),
      .mem_write_en(mem_write_en[gi]), .mem_read_en(mem_read_en[gi]),
      .mem_data_in(mem_data_in[gi]),
      .cpu_halt(cpu_halt[gi]), .dma_busy(dma_busy[gi]), .dma_done(dma_done[gi])
    );

    // Memory model: data is valid LAT cycles after the read pulse.
    // At other times the data bus carries random junk.
    always @(posedge clk) begin
      pa[0] <= mem_addr[gi];
      pv[0] <= mem_read_en[gi];
      for (int s = 1; s < 8; s++) begin
        pa[s] <= pa[s-1];
        pv[s] <= pv[s-1];
      end
      junk <= 8'($urandom);
    end
    assign mem_data_in[gi] = pv[LAT-1] ? ram[pa[LAT-1]] : junk;
  end

  task automatic chk(input bit ok, input string name, input int k,
                     input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, k, cyc, got, exp);
    end
  endtask

  // Monitor and scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int per;
      per = 256 * (2 + k + 2);
      if (rst) begin
        chk(!cpu_halt[k] && !dma_busy[k] && !dma_done[k], "reset_flags", k,
            {29'd0, cpu_halt[k], dma_busy[k], dma_done[k]}, 32'd0);
        chk(mem_addr[k] == cpu_addr && mem_write_en[k] == cpu_write_en &&
            mem_read_en[k] == cpu_read_en, "reset_passthru", k,
            {14'd0, mem_write_en[k], mem_read_en[k], mem_addr[k]},
            {14'd0, cpu_write_en, cpu_read_en, cpu_addr});
        halt_cnt[k] = 0;
        busy_cnt[k] = 0;
        post_done[k] = 0;
      end else begin
        if (post_done[k]) begin
          chk(!cpu_halt[k] && !dma_busy[k] && !dma_done[k], "release_after_done", k,
              {29'd0, cpu_halt[k], dma_busy[k], dma_done[k]}, 32'd0);
          post_done[k] = 0;
        end
        if (!dma_busy[k]) begin
          chk(mem_addr[k] == cpu_addr && mem_data_out[k] == cpu_data_out &&
              mem_write_en[k] == cpu_write_en && mem_read_en[k] == cpu_read_en,
              "passthru", k,
              {6'd0, mem_write_en[k], mem_read_en[k], mem_data_out[k], mem_addr[k]},
              {6'd0, cpu_write_en, cpu_read_en, cpu_data_out, cpu_addr});
        end else begin
          if (mem_write_en[k]) begin
            if (wq[k].size() == 0) begin
              chk(1'b0, "unexpected_write", k, {16'd0, mem_addr[k]}, 32'd0);
            end else begin
              logic [7:0] ed;
              ed = wq[k].pop_front();
              chk(mem_addr[k] == 16'h2004 && mem_data_out[k] == ed && !mem_read_en[k],
                  "oam_write", k, {8'd0, mem_data_out[k], mem_addr[k]},
                  {8'd0, ed, 16'h2004});
            end
          end
          if (mem_read_en[k]) begin
            if (rq[k].size() == 0) begin
              chk(1'b0, "unexpected_read", k, {16'd0, mem_addr[k]}, 32'd0);
            end else begin
              logic [15:0] ea;
              ea = rq[k].pop_front();
              chk(mem_addr[k] == ea, "src_read", k, {16'd0, mem_addr[k]}, {16'd0, ea});
            end
          end
        end
        if (cpu_halt[k]) halt_cnt[k]++;
        if (dma_busy[k]) busy_cnt[k]++;
        if (dma_done[k]) begin
          chk(cyc == trig_cyc + HS + per + 1, "done_cycle", k,
              32'(cyc - trig_cyc), 32'(HS + per + 1));
          chk(halt_cnt[k] == HS + per + 1, "halt_window", k,
              32'(halt_cnt[k]), 32'(HS + per + 1));
          chk(busy_cnt[k] == per + 1, "busy_window", k,
              32'(busy_cnt[k]), 32'(per + 1));
          chk(wq[k].size() == 0 && rq[k].size() == 0, "all_bytes_moved", k,
              32'(wq[k].size() + rq[k].size()), 32'd0);
          halt_cnt[k] = 0;
          busy_cnt[k] = 0;
          post_done[k] = 1;
        end
      end
    end
  end

  task automatic idle_bus();
    cpu_addr = 16'h0000;
    cpu_data_out = 8'h00;
    cpu_write_en = 1'b0;
    cpu_read_en = 1'b0;
  endtask

  task automatic noise_bus();
    cpu_addr = 16'($urandom);
    if (cpu_addr == 16'h4014) cpu_addr = 16'h4015;
    cpu_data_out = 8'($urandom);
    cpu_write_en = 1'($urandom);
    cpu_read_en = 1'($urandom);
  endtask

  // Caller is aligned 1 time unit after a posedge.
  task automatic do_dma(input logic [7:0] page, input bit retrig, input bit noise);
    int n;
    trig_cyc = cyc;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) begin
        rq[k].push_back({page, 8'(i)});
        wq[k].push_back(ram[{page, 8'(i)}]);
      end
    end
    cpu_addr = 16'h4014;
    cpu_data_out = page;
    cpu_write_en = 1'b1;
    cpu_read_en = 1'b0;
    @(posedge clk); #1;
    if (retrig) begin
      cpu_addr = 16'h4014;
      cpu_data_out = 8'h03;
      cpu_write_en = 1'b1;
    end else begin
      idle_bus();
    end
    @(posedge clk); #1;
    n = 0;
    while (cpu_halt[0] || cpu_halt[1]) begin
      if (noise) noise_bus(); else idle_bus();
      @(posedge clk); #1;
      n++;
      if (n > 3000) begin
        $display("FAIL dma_timeout page=%h: halt still high after %0d cycles, required drop", page, n);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
      end
    end
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int a = 0; a < 65536; a++) ram[a] = 8'($urandom);
    idle_bus();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Pass-through: write 55 to 0200, read 0300, then random traffic.
    cpu_addr = 16'h0200; cpu_data_out = 8'h55; cpu_write_en = 1'b1;
    @(posedge clk); #1;
    cpu_addr = 16'h0300; cpu_write_en = 1'b0; cpu_read_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      noise_bus();
      @(posedge clk); #1;
    end
    idle_bus();
    @(posedge clk); #1;

    // Full DMA from page 02 with a known pattern.
    for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'hA5;
    do_dma(8'h02, 1'b0, 1'b0);

    // Page FF reads FF00..FFFF and must not wrap into page 00.
    do_dma(8'hFF, 1'b0, 1'b0);

    // A retrigger during the settle window is ignored. CPU strobes during the busy window are blocked.
    for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'($urandom);
    do_dma(8'h02, 1'b1, 1'b1);

    // Random pages.
    do_dma(8'($urandom), 1'b0, 1'b1);

    // Reset during the read of byte 40 aborts the transfer.
    do_dma_abort();

    // Recovery after the abort.
    do_dma(8'($urandom), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic do_dma_abort();
    int n;
    trig_cyc = cyc;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) begin
        rq[k].push_back({8'h02, 8'(i)});
        wq[k].push_back(ram[{8'h02, 8'(i)}]);
      end
    end
    cpu_addr = 16'h4014; cpu_data_out = 8'h02; cpu_write_en = 1'b1;
    @(posedge clk); #1;
    idle_bus();
    n = 0;
    while (!(dma_busy[0] && mem_read_en[0] && mem_addr[0] == 16'h0240)) begin
      @(posedge clk); #1;
      n++;
      if (n > 2000) begin
        $display("FAIL abort_wait: byte 40 read not seen after %0d cycles, required within 2000", n);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
      end
    end
    rst = 1'b1;
    cpu_addr = 16'h1234;
    for (int k = 0; k < 2; k++) begin
      rq[k].delete();
      wq[k].delete();
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_bus();
    repeat (40) @(posedge clk);
    #1;
  endtask

endmodule
